// File: rtl/nios2_mul_seq_ctrl_pkg.sv
// Shared definitions for the sequenced 32x32 multiplier: op codes, FSM states, pass order.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package nios2_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,  // low word of product
        OP_MULXUU = 2'b01,  // high word, both unsigned
        OP_MULXSS = 2'b10,  // high word, both signed
        OP_MULXSU = 2'b11   // high word, src1 signed, src2 unsigned
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CORR  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Partial-product pass index, in issue order
    typedef logic [1:0] pp_t;
    localparam pp_t PP_LL = 2'd0;  // a[15:0]  * b[15:0]
    localparam pp_t PP_HL = 2'd1;  // a[31:16] * b[15:0]
    localparam pp_t PP_LH = 2'd2;  // a[15:0]  * b[31:16]
    localparam pp_t PP_HH = 2'd3;  // a[31:16] * b[31:16]

    localparam logic [5:0] SH_LL = 6'd0;
    localparam logic [5:0] SH_HL = 6'd16;
    localparam logic [5:0] SH_LH = 6'd16;
    localparam logic [5:0] SH_HH = 6'd32;

    function automatic logic [5:0] pp_shift(input pp_t k);
        case (k)
            PP_LL:   return SH_LL;
            PP_HL:   return SH_HL;
            PP_LH:   return SH_LH;
            default: return SH_HH;
        endcase
    endfunction

    function automatic logic pp_a_hi(input pp_t k);
        return (k == PP_HL) || (k == PP_HH);
    endfunction

    function automatic logic pp_b_hi(input pp_t k);
        return (k == PP_LH) || (k == PP_HH);
    endfunction

endpackage

// File: rtl/nios2_mul_seq_ctrl_if.sv
// Request/response bundle between the CPU and the sequenced multiplier.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
// Ports: req_valid/req_ready/req_op/req_src1/req_src2, rsp_valid/rsp_ready/rsp_result, busy.
interface nios2_mul_seq_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        busy;

    // CPU side
    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, busy
    );

    // Multiplier side
    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_result, busy
    );
endinterface

// File: rtl/nios2_mul_seq_ctrl_mul16_cell.sv
// 16x16 unsigned multiplier with MUL_LATENCY output registers and a matching valid pipeline.
// Latency: MUL_LATENCY cycles from in_vld to out_vld.
// Backpressure: none; products always advance, clr flushes products and valids.
// Ports: clk, clr (sync clear), in_vld/in_a/in_b, out_vld/out_prod, pending (any stage valid).
module nios2_mul16_cell #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_vld,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_vld,
    output logic [31:0] out_prod,
    output logic        pending
);
    logic [31:0]            prod_q [MUL_LATENCY];
    logic [MUL_LATENCY-1:0] vld_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) prod_q[i] <= '0;
        end else begin
            vld_q[0]  <= in_vld;
            prod_q[0] <= 32'(in_a) * 32'(in_b);
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign out_vld  = vld_q[MUL_LATENCY-1];
    assign out_prod = prod_q[MUL_LATENCY-1];
    assign pending  = |vld_q;

endmodule

// File: rtl/nios2_mul_seq_ctrl.sv
// 32x32 multiply (MUL/MULXUU/MULXSS/MULXSU) by time-sharing one 16x16 cell over 3-4 passes.
// Latency: accept to first rsp_valid = N + MUL_LATENCY + 2 cycles (N = 3 for MUL, 4 otherwise).
// Backpressure: req_ready only in IDLE; rsp_result held while rsp_valid & ~rsp_ready.
// Ports: clk, reset (sync, active-high), bus (slave modport of nios2_mul_seq_ctrl_if).
module nios2_mul_seq_ctrl
    import nios2_mul_pkg::*;
#(
    parameter int MUL_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    nios2_mul_seq_ctrl_if.slave  bus
);
    state_t      state;
    pp_t         k;        // pass currently driving the cell
    pp_t         land_k;   // pass whose product lands next
    op_t         op_q;
    logic [31:0] a_q, b_q;
    logic [63:0] acc;

    logic        req_ready_q, rsp_valid_q, busy_q;
    logic [31:0] rsp_result_q;

    logic        cell_out_vld, cell_pending;
    logic [31:0] cell_prod;
    logic [15:0] cell_a, cell_b;

    logic        accept;
    pp_t         last_k;
    logic [63:0] addend;
    logic        sa, sb;
    logic [31:0] hi_corr, corr_result;

    assign accept = req_ready_q & bus.req_valid;
    assign last_k = (op_q == OP_MUL) ? PP_LH : PP_HH;  // MUL never needs the HH pass

    assign cell_a = pp_a_hi(k) ? a_q[31:16] : a_q[15:0];
    assign cell_b = pp_b_hi(k) ? b_q[31:16] : b_q[15:0];

    // Passes land in issue order, so a landing counter recovers each product's shift.
    assign addend = {32'd0, cell_prod} << pp_shift(land_k);

    // Signed high word from the unsigned product: subtract the other operand for each
    // operand that is treated as signed and negative.
    assign sa          = (op_q == OP_MULXSS) || (op_q == OP_MULXSU);
    assign sb          = (op_q == OP_MULXSS);
    assign hi_corr     = acc[63:32] - ((sa & a_q[31]) ? b_q : 32'd0)
                                    - ((sb & b_q[31]) ? a_q : 32'd0);
    assign corr_result = (op_q == OP_MUL) ? acc[31:0] : hi_corr;

    nios2_mul16_cell #(.MUL_LATENCY(MUL_LATENCY)) u_cell (
        .clk      (clk),
        .clr      (reset),
        .in_vld   (state == ST_ISSUE),
        .in_a     (cell_a),
        .in_b     (cell_b),
        .out_vld  (cell_out_vld),
        .out_prod (cell_prod),
        .pending  (cell_pending)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            k            <= PP_LL;
            op_q         <= OP_MUL;
            a_q          <= '0;
            b_q          <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q        <= op_t'(bus.req_op);
                        a_q         <= bus.req_src1;
                        b_q         <= bus.req_src2;
                        k           <= PP_LL;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    k <= k + 2'd1;
                    if (k == last_k) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Empty pipeline means the last product has already been accumulated
                    if (!cell_pending) state <= ST_CORR;
                end
                ST_CORR: begin
                    rsp_result_q <= corr_result;
                    rsp_valid_q  <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            land_k <= PP_LL;
        end else if (accept) begin
            acc    <= '0;
            land_k <= PP_LL;
        end else if (cell_out_vld) begin
            acc    <= acc + addend;
            land_k <= land_k + 2'd1;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_nios2_mul_seq_ctrl.sv
// Directed bench for nios2_mul_seq_ctrl: vector table plus backpressure and mid-op reset sequences.
// Latency: checks accept-to-rsp_valid cycle counts against hand-computed values.
// Backpressure: holds rsp_ready low for a window and probes for ignored requests.
module tb_nios2_mul_seq_ctrl;
    import nios2_mul_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nios2_mul_seq_ctrl_if bus ();

    nios2_mul_seq_ctrl #(.MUL_LATENCY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Called at a negedge with the block idle; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        // Scramble inputs: the latched operands must be used from here on
        bus.req_op    = 2'($urandom_range(0, 3));
        bus.req_src1  = $urandom();
        bus.req_src2  = $urandom();
        chk("accept_busy", 32'(bus.busy), 32'd1);
        chk("accept_req_ready", 32'(bus.req_ready), 32'd0);
    endtask

    // Counts negedges from the accept cycle to the first rsp_valid, bounded.
    task automatic await_rsp(input string name, input logic [31:0] exp, input int lat);
        int cyc = 0;
        while (!bus.rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(lat));
        chk({name, "_result"}, bus.rsp_result, exp);
    endtask

    initial begin
        vecs[0]  = '{OP_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 6};
        vecs[1]  = '{OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7};
        vecs[2]  = '{OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 7};
        vecs[3]  = '{OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 7};
        vecs[4]  = '{OP_MULXSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 7};
        vecs[5]  = '{OP_MULXUU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 7};
        vecs[6]  = '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 6};
        vecs[7]  = '{OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 6};
        vecs[8]  = '{OP_MULXSS, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 7};
        vecs[9]  = '{OP_MULXSS, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7};
        vecs[10] = '{OP_MULXUU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 7};

        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.rsp_ready = 1'b1;
        reset         = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_result", bus.rsp_result, 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            await_rsp($sformatf("vec%0d", i), vecs[i].res, vecs[i].lat);
            @(negedge clk);
            chk($sformatf("vec%0d_rsp_done", i), 32'(bus.rsp_valid), 32'd0);
            chk($sformatf("vec%0d_req_ready", i), 32'(bus.req_ready), 32'd1);
        end

        // Backpressure: response held, competing requests ignored
        bus.rsp_ready = 1'b0;
        issue(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        await_rsp("bp", 32'hFFFF_FFFE, 7);
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = OP_MUL;
            bus.req_src1  = 32'd3;
            bus.req_src2  = 32'd5;
            @(negedge clk);
            chk($sformatf("bp%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp%0d_result", i), bus.rsp_result, 32'hFFFF_FFFE);
            chk($sformatf("bp%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
        chk("bp_release_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("bp_no_stale_accept", 32'(bus.busy), 32'd0);

        // Reset pulse at accept+3 drops the operation
        issue(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (bus.rsp_valid) seen = 1'b1;
            end
            chk("midrst_no_response", 32'(seen), 32'd0);
        end
        issue(OP_MUL, 32'd7, 32'd6);
        await_rsp("after_rst_mul", 32'h0000_002A, 6);
        @(negedge clk);
        chk("after_rst_req_ready", 32'(bus.req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
